// File: rtl/tt_um_multicount_anonymousseal.sv
// Multi-channel counter/timer tile: up to four counters sharing one prescaler,
// driven by a strobed command port. Optional wrap flags: MULTICOUNT_WRAP_FLAG_EN.
module tt_um_multicount_anonymousseal #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned PRESCALE_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_LOAD_LO  = 3'd1;
    localparam logic [2:0] CMD_LOAD_HI  = 3'd2;
    localparam logic [2:0] CMD_COMMIT   = 3'd3;
    localparam logic [2:0] CMD_SET_UP   = 3'd4;
    localparam logic [2:0] CMD_SET_DOWN = 3'd5;
    localparam logic [2:0] CMD_CLEAR    = 3'd6;
    localparam logic [2:0] CMD_SNAPSHOT = 3'd7;

    logic [1:0]  w_sel;
    logic        w_run;
    logic        w_bsel;
    logic [2:0]  w_cmd;
    logic        w_stb;
    logic        w_fire;
    logic        w_tick;
    logic        r_stb_q;
    logic [15:0] r_shadow;
    logic [15:0] r_snap;
    logic [15:0] w_cnt16 [4];
`ifdef MULTICOUNT_WRAP_FLAG_EN
    logic [3:0]  w_flags;
    logic        w_snap_flags;
`endif

    assign w_sel  = ui_in[1:0];
    assign w_run  = ui_in[2];
    assign w_bsel = ui_in[3];
    assign w_cmd  = ui_in[6:4];
    assign w_stb  = ui_in[7];

    // One fire per strobe pulse, however long it is held.
    assign w_fire = ena & w_stb & ~r_stb_q;

`ifdef MULTICOUNT_WRAP_FLAG_EN
    assign w_snap_flags = w_fire & (w_cmd == CMD_NOP);
`endif

    generate
        if (PRESCALE_BITS == 0) begin : g_nopre
            assign w_tick = ena & w_run;
        end else begin : g_pre
            logic [PRESCALE_BITS-1:0] r_pre;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pre <= '0;
                end else if (ena & w_run) begin
                    r_pre <= r_pre + PRESCALE_BITS'(1);
                end
            end
            assign w_tick = ena & w_run & (&r_pre);
        end
    endgenerate

    // Shared command state: strobe history, load shadow and snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_q  <= 1'b0;
            r_shadow <= 16'h0000;
            r_snap   <= 16'h0000;
        end else begin
            if (ena) begin
                r_stb_q <= w_stb;
            end
            if (w_fire) begin
                case (w_cmd)
                    CMD_LOAD_LO:  r_shadow[7:0]  <= uio_in;
                    CMD_LOAD_HI:  r_shadow[15:8] <= uio_in;
                    CMD_SNAPSHOT: r_snap         <= w_cnt16[w_sel];
`ifdef MULTICOUNT_WRAP_FLAG_EN
                    CMD_NOP:      r_snap         <= {12'h000, w_flags};
`endif
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar c = 0; c < 4; c++) begin : g_ch
            if (c < CHANNELS) begin : g_on
                logic [WIDTH-1:0] r_cnt;
                logic             r_dir;
                logic             w_hit;
                logic             w_load;
                logic             w_clr;

                assign w_hit  = w_fire & (w_sel == 2'(c));
                assign w_load = w_hit & (w_cmd == CMD_COMMIT);
                assign w_clr  = w_hit & (w_cmd == CMD_CLEAR);

                // COMMIT/CLEAR win over a coincident tick; direction changes land after it.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cnt <= '0;
                        r_dir <= 1'b1;
                    end else begin
                        if (w_load) begin
                            r_cnt <= r_shadow[WIDTH-1:0];
                        end else if (w_clr) begin
                            r_cnt <= '0;
                        end else if (w_tick) begin
                            r_cnt <= r_dir ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
                        end
                        if (w_hit & (w_cmd == CMD_SET_UP)) begin
                            r_dir <= 1'b1;
                        end else if (w_hit & (w_cmd == CMD_SET_DOWN)) begin
                            r_dir <= 1'b0;
                        end
                    end
                end

                assign w_cnt16[c] = 16'(r_cnt);

`ifdef MULTICOUNT_WRAP_FLAG_EN
                logic r_wrap;
                logic w_wrap_evt;

                assign w_wrap_evt = w_tick & ~w_load & ~w_clr &
                                    (r_dir ? (&r_cnt) : (r_cnt == '0));

                // A wrap on the same edge as a flag read keeps the flag set.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_wrap <= 1'b0;
                    end else if (w_wrap_evt) begin
                        r_wrap <= 1'b1;
                    end else if (w_clr | w_snap_flags) begin
                        r_wrap <= 1'b0;
                    end
                end

                assign w_flags[c] = r_wrap | w_wrap_evt;
`endif
            end else begin : g_off
                assign w_cnt16[c] = 16'h0000;
`ifdef MULTICOUNT_WRAP_FLAG_EN
                assign w_flags[c] = 1'b0;
`endif
            end
        end
    endgenerate

    assign uo_out  = w_bsel ? r_snap[15:8] : r_snap[7:0];
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
